// File: rtl/bot_state_if.sv
// bot_state_if
//   Groups the reader-facing strobe, the two bot state words and the
//   integrator results into one bundle.
//   master : the file-reader side (drives read_done and the *_bin words,
//            observes results, busy and output_check)
//   slave  : the integrator side
//
// Handshake: read_done is a level from the reader; a 0->1 transition seen
// while the integrator is idle means all eight *_bin words are valid on that
// same clock edge. The integrator answers with a one-cycle output_check
// pulse once the results are final; results then stay put until the next
// accepted capture. Rising edges that arrive while busy are dropped.
interface bot_state_if;
  logic        read_done;
  logic [15:0] x1_bin, y1_bin, vx1_bin, vy1_bin;
  logic [15:0] x2_bin, y2_bin, vx2_bin, vy2_bin;
  logic [15:0] x1_next, y1_next, x2_next, y2_next;
  logic        collision;
  logic [3:0]  step_count;
  logic        busy;
  logic        output_check;

  modport master (
    output read_done,
    output x1_bin, y1_bin, vx1_bin, vy1_bin,
    output x2_bin, y2_bin, vx2_bin, vy2_bin,
    input  x1_next, y1_next, x2_next, y2_next,
    input  collision, step_count, busy, output_check
  );

  modport slave (
    input  read_done,
    input  x1_bin, y1_bin, vx1_bin, vy1_bin,
    input  x2_bin, y2_bin, vx2_bin, vy2_bin,
    output x1_next, y1_next, x2_next, y2_next,
    output collision, step_count, busy, output_check
  );
endinterface

// File: rtl/bot_state_integrator.sv
// bot_state_integrator
//   Captures bot 1 / bot 2 position and velocity (signed Q4.11) on a rising
//   edge of read_done, integrates positions forward STEPS times with
//   dt = 2^-DT_SHIFT, and after each step compares squared separation
//   against SAFE_DIST_SQ. Finishes with a one-cycle output_check pulse.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   bus          bot_state_if.slave (read_done, *_bin in; *_next, collision,
//                step_count, busy, output_check out)
//   dbg_state_o  current FSM state (IDLE=0, INTEGRATE=1, CHECK=2, DONE=3)
//
// Build option
//   BOT_INTEG_SAT_EN  defined: position adds saturate at 0x7FFF / 0x8000.
//                     undefined: position adds wrap modulo 2^16.
module bot_state_integrator #(
  parameter int          FRAC_BITS    = 11,
  parameter int          STEPS        = 8,
  parameter int          DT_SHIFT     = 4,
  parameter logic [35:0] SAFE_DIST_SQ = 36'h0_0040_0000
) (
  input  logic       clk,
  input  logic       rst,
  bot_state_if.slave bus,
  output logic [1:0] dbg_state_o
);

  // step_count is 4 bits and the squared-distance threshold is in Q(2*FRAC_BITS)
  if (STEPS < 1 || STEPS > 15 || FRAC_BITS < 1 || FRAC_BITS > 15) begin : g_bad_cfg
    $error("bot_state_integrator: STEPS must be 1..15 and FRAC_BITS 1..15");
  end

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_INTEG = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        read_done_q;
  logic [15:0] x1_q, y1_q, x2_q, y2_q, x1_d, y1_d, x2_d, y2_d;
  logic [15:0] vx1_q, vy1_q, vx2_q, vy2_q, vx1_d, vy1_d, vx2_d, vy2_d;
  logic        collision_q, collision_d;
  logic [3:0]  step_q, step_d;
  logic        rd_edge;

  logic signed [16:0] dx, dy;
  logic signed [33:0] dx_w, dy_w, dx_sq, dy_sq;
  logic        [34:0] d2;
  logic               too_close;

  // Position plus one time step of velocity (arithmetic shift keeps sign).
  function automatic logic [15:0] pos_add(input logic [15:0] p, input logic [15:0] v);
    logic [15:0] inc;
    logic [15:0] sum;
    inc = 16'($signed(v) >>> DT_SHIFT);
    sum = p + inc;
`ifdef BOT_INTEG_SAT_EN
    // Overflow only when both operands share a sign the result lost.
    if ((p[15] == inc[15]) && (sum[15] != p[15])) begin
      sum = p[15] ? 16'h8000 : 16'h7FFF;
    end
`endif
    return sum;
  endfunction

  assign rd_edge = bus.read_done & ~read_done_q;

  // Separation check on the registered positions; squares are non-negative
  // and below 2^33, so the 34-bit signed products never wrap.
  always_comb begin
    dx        = {x1_q[15], x1_q} - {x2_q[15], x2_q};
    dy        = {y1_q[15], y1_q} - {y2_q[15], y2_q};
    dx_w      = {{17{dx[16]}}, dx};
    dy_w      = {{17{dy[16]}}, dy};
    dx_sq     = dx_w * dx_w;
    dy_sq     = dy_w * dy_w;
    d2        = {1'b0, dx_sq} + {1'b0, dy_sq};
    too_close = ({1'b0, d2} < SAFE_DIST_SQ);
  end

  always_comb begin
    state_d     = state_q;
    x1_d        = x1_q;
    y1_d        = y1_q;
    x2_d        = x2_q;
    y2_d        = y2_q;
    vx1_d       = vx1_q;
    vy1_d       = vy1_q;
    vx2_d       = vx2_q;
    vy2_d       = vy2_q;
    collision_d = collision_q;
    step_d      = step_q;
    case (state_q)
      S_IDLE: begin
        if (rd_edge) begin
          x1_d        = bus.x1_bin;
          y1_d        = bus.y1_bin;
          x2_d        = bus.x2_bin;
          y2_d        = bus.y2_bin;
          vx1_d       = bus.vx1_bin;
          vy1_d       = bus.vy1_bin;
          vx2_d       = bus.vx2_bin;
          vy2_d       = bus.vy2_bin;
          collision_d = 1'b0;
          step_d      = 4'd0;
          state_d     = S_INTEG;
        end
      end
      S_INTEG: begin
        x1_d    = pos_add(x1_q, vx1_q);
        y1_d    = pos_add(y1_q, vy1_q);
        x2_d    = pos_add(x2_q, vx2_q);
        y2_d    = pos_add(y2_q, vy2_q);
        step_d  = step_q + 4'd1;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (too_close) begin
          collision_d = 1'b1;
          state_d     = S_DONE;
        end else if (step_q == 4'(STEPS)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_INTEG;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      // Starts high so a level held across reset release is not an edge.
      read_done_q <= 1'b1;
      x1_q        <= '0;
      y1_q        <= '0;
      x2_q        <= '0;
      y2_q        <= '0;
      vx1_q       <= '0;
      vy1_q       <= '0;
      vx2_q       <= '0;
      vy2_q       <= '0;
      collision_q <= 1'b0;
      step_q      <= '0;
    end else begin
      state_q     <= state_d;
      read_done_q <= bus.read_done;
      x1_q        <= x1_d;
      y1_q        <= y1_d;
      x2_q        <= x2_d;
      y2_q        <= y2_d;
      vx1_q       <= vx1_d;
      vy1_q       <= vy1_d;
      vx2_q       <= vx2_d;
      vy2_q       <= vy2_d;
      collision_q <= collision_d;
      step_q      <= step_d;
    end
  end

  assign bus.x1_next      = x1_q;
  assign bus.y1_next      = y1_q;
  assign bus.x2_next      = x2_q;
  assign bus.y2_next      = y2_q;
  assign bus.collision    = collision_q;
  assign bus.step_count   = step_q;
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.output_check = (state_q == S_DONE);
  assign dbg_state_o      = state_q;

endmodule
